// File: rtl/seg_adder_pipe.sv
// Segmented pipelined adder/subtractor: one SEG-bit segment per stage, valid/ready on both sides.
// Optional overflow/zero flags are built when SEG_ADDER_PIPE_FLAGS_EN is defined.
module seg_adder_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEG   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned STAGES = WIDTH / SEG;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign b_eff    = sub ? ~in2 : in2;
   assign c0       = sub ? ~cin : cin;

   genvar k;
   for (k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG-1:0]         a_seg;
      logic [SEG-1:0]         b_seg;
      logic                   c_in;
      logic                   v_in;
      logic [SEG:0]           seg_add;
      logic [(k+1)*SEG-1:0]   acc_d;
      logic [(k+1)*SEG-1:0]   acc_q;
      logic                   carry_q;
      logic                   valid_q;

      if (k == 0) begin : g_first
         assign a_seg = in1[SEG-1:0];
         assign b_seg = b_eff[SEG-1:0];
         assign c_in  = c0;
         assign v_in  = in_valid;
         assign acc_d = seg_add[SEG-1:0];
      end else begin : g_next
         assign a_seg = g_stage[k-1].g_up.a_up_q[SEG-1:0];
         assign b_seg = g_stage[k-1].g_up.b_up_q[SEG-1:0];
         assign c_in  = g_stage[k-1].carry_q;
         assign v_in  = g_stage[k-1].valid_q;
         assign acc_d = {seg_add[SEG-1:0], g_stage[k-1].acc_q};
      end

      assign seg_add = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

      // Data registers load only with a valid beat so the last result stays visible.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            acc_q   <= '0;
         end else if (adv) begin
            valid_q <= v_in;
            if (v_in) begin
               carry_q <= seg_add[SEG];
               acc_q   <= acc_d;
            end
         end
      end

      if (k < STAGES - 1) begin : g_up
         localparam int unsigned UpW = (STAGES - k - 1) * SEG;
         logic [UpW-1:0] a_up_d;
         logic [UpW-1:0] b_up_d;
         logic [UpW-1:0] a_up_q;
         logic [UpW-1:0] b_up_q;

         if (k == 0) begin : g_src_in
            assign a_up_d = in1[WIDTH-1:SEG];
            assign b_up_d = b_eff[WIDTH-1:SEG];
         end else begin : g_src_prev
            assign a_up_d = g_stage[k-1].g_up.a_up_q[UpW+SEG-1:SEG];
            assign b_up_d = g_stage[k-1].g_up.b_up_q[UpW+SEG-1:SEG];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               a_up_q <= '0;
               b_up_q <= '0;
            end else if (adv && v_in) begin
               a_up_q <= a_up_d;
               b_up_q <= b_up_d;
            end
         end
      end
   end

   assign sum       = g_stage[STAGES-1].acc_q;
   assign carry_out = g_stage[STAGES-1].carry_q;
   assign out_valid = g_stage[STAGES-1].valid_q;

`ifdef SEG_ADDER_PIPE_FLAGS_EN
   logic overflow_q;
   logic zero_q;
   logic a_msb;
   logic b_msb;

   assign a_msb = g_stage[STAGES-1].a_seg[SEG-1];
   assign b_msb = g_stage[STAGES-1].b_seg[SEG-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else if (adv && g_stage[STAGES-1].v_in) begin
         overflow_q <= (a_msb == b_msb) && (g_stage[STAGES-1].seg_add[SEG-1] != a_msb);
         zero_q     <= (g_stage[STAGES-1].acc_d == '0);
      end
   end

   assign overflow = overflow_q;
   assign zero     = zero_q;
`else
   assign overflow = 1'b0;
   assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_seg_adder_pipe.sv
// Scoreboard bench for seg_adder_pipe at WIDTH=16, SEG=4: the driver queues expected results,
// a monitor pops and compares whenever a result transfers.
module tb_seg_adder_pipe;

   localparam int W  = 16;
   localparam int S  = 4;
   localparam int ST = W / S;

`ifdef SEG_ADDER_PIPE_FLAGS_EN
   localparam bit FlagsOn = 1'b1;
`else
   localparam bit FlagsOn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in1 = '0;
   logic [W-1:0] in2 = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;
   logic         zero;

   seg_adder_pipe #(.WIDTH(W), .SEG(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      logic         z;
      int           acc;
      bit           chk_lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor samples late in the low phase, after the driver has settled out_ready.
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got sum 0x%0h, expected no result", sum);
            end else begin
               mon_e = exp_q.pop_front();
               check("sum", sum, mon_e.s);
               check("carry_out", carry_out, mon_e.co);
               check("overflow", overflow, mon_e.ov & FlagsOn);
               check("zero", zero, mon_e.z & FlagsOn);
               if (mon_e.chk_lat) check("latency", cyc - mon_e.acc, ST - 1);
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sb, input logic [W-1:0] es, input logic eco,
                       input logic eov, input logic ez, input bit lat);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      #1;
      in1 = a; in2 = b; cin = ci; sub = sb; in_valid = 1'b1;
      #1;
      while (!in_ready) begin
         n++;
         if (n > 50) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         #2;
      end
      e.s = es; e.co = eco; e.ov = eov; e.z = ez; e.acc = cyc + 1; e.chk_lat = lat;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_stream(input bit with_stall);
      logic [W-1:0] snap;
      for (int i = 0; i < 8; i++) begin
         if (with_stall && i == 4) begin
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               #1;
               out_ready = 1'b0;
               in_valid  = 1'b1;
               in1 = 16'hAAAA; in2 = 16'h5555; cin = 1'b0; sub = 1'b0;
               #1;
               if (j == 0) snap = sum;
               check("stall_in_ready", in_ready, 0);
               check("stall_out_valid", out_valid, 1);
               check("stall_sum_hold", sum, snap);
            end
            @(negedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         send(W'(i), W'(i + 1), 1'b0, 1'b0, W'(2 * i + 1), 1'b0, 1'b0, 1'b0, !with_stall);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_carry_out", carry_out, 0);
      check("rst_overflow", overflow, 0);
      check("rst_zero", zero, 0);
      check("rst_in_ready", in_ready, 1);

      // Directed vectors, back to back.
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
      send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
      send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b1);
      send(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
      send(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();

      run_stream(1'b0);
      drain();
      run_stream(1'b1);
      drain();

      // Reset with three beats in flight.
      send(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0, 1'b0, 1'b0);
      send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0);
      send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum", sum, 0);
      check("midrst_carry_out", carry_out, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #2;
         check("postrst_out_valid", out_valid, 0);
      end

      send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
